// File: rtl/window_feeder_pkg.sv
// Shared pixel and window types for the window feeder and convolution stage.
package window_feeder_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Index 0 is p0 (oldest row, oldest column); index 8 is p8 (newest pixel).
  typedef logic [8:0][PIX_W-1:0] window_t;

endpackage

// File: rtl/window_feeder_line_buffer.sv
// One line of pixel storage: single port, synchronous write, combinational
// read so the old value at an address is available in the cycle it is overwritten.
module line_buffer
  import window_feeder_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  // Read returns the pre-write contents of the addressed entry.
  always_comb rdata = mem[addr];

  // Storage is intentionally not reset; stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_feeder.sv
// Streaming 3x3 window generator: raster pixels in, registered neighbourhood out.
// Optional build macro WINDOW_FEEDER_FRAME_DONE_EN adds the frame_done pulse output.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic   clk,
  input  logic   rst_n,
  input  pixel_t pix_in,
  input  logic   pix_sof,
  input  logic   pix_valid,
  output logic   pix_ready,
  output pixel_t p0,
  output pixel_t p1,
  output pixel_t p2,
  output pixel_t p3,
  output pixel_t p4,
  output pixel_t p5,
  output pixel_t p6,
  output pixel_t p7,
  output pixel_t p8,
`ifdef WINDOW_FEEDER_FRAME_DONE_EN
  output logic   frame_done,
`endif
  output logic   win_valid,
  input  logic   win_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  window_t       win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic          accept;
  pixel_t        lb0_rd, lb1_rd;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // Position of the pixel being offered; start-of-frame overrides the counters.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (pix_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Window shift, counter advance and output-valid tracking.
  always_comb begin
    win_d       = win_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      win_valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
    end
  end

  // lb0 holds row r-1, lb1 holds row r-2; both shift down one row per accept.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  assign p0        = win_q[0];
  assign p1        = win_q[1];
  assign p2        = win_q[2];
  assign p3        = win_q[3];
  assign p4        = win_q[4];
  assign p5        = win_q[5];
  assign p6        = win_q[6];
  assign p7        = win_q[7];
  assign p8        = win_q[8];
  assign win_valid = win_valid_q;

`ifdef WINDOW_FEEDER_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  // Pulse after the last pixel of a frame is taken, regardless of downstream stall.
  always_comb frame_done_d = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Frame-done register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_q <= 1'b0;
    else        frame_done_q <= frame_done_d;
  end

  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder at a 4x4 image size.
module tb_window_feeder;
  import window_feeder_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic   clk = 1'b0;
  logic   rst_n;
  pixel_t pix_in;
  logic   pix_sof, pix_valid, pix_ready;
  pixel_t p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic   win_valid, win_ready;
`ifdef WINDOW_FEEDER_FRAME_DONE_EN
  logic   frame_done;
`endif

  int checks   = 0;
  int failures = 0;
  int wins     = 0;
  window_t exp_q[$];

  int pos_r = 0;
  int pos_c = 0;

  always #5 clk = ~clk;

  window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_sof(pix_sof),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
`ifdef WINDOW_FEEDER_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .win_valid(win_valid), .win_ready(win_ready)
  );

  function automatic window_t cur_win();
    window_t w;
    w[0] = p0; w[1] = p1; w[2] = p2; w[3] = p3; w[4] = p4;
    w[5] = p5; w[6] = p6; w[7] = p7; w[8] = p8;
    return w;
  endfunction

  function automatic pixel_t pv(input int base, input int r, input int c);
    return pixel_t'(base + 16 * r + c);
  endfunction

  function automatic window_t model_win(input int base, input int r, input int c);
    window_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3 * i + j] = pv(base, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops and compares every window handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && win_valid && win_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_window: got %h expected none", cur_win());
        end else begin
          window_t e;
          e = exp_q.pop_front();
          if (cur_win() !== e) begin
            failures++;
            $display("FAIL window: got %h expected %h", cur_win(), e);
          end
        end
        wins++;
      end
    end
  end

  // Offers one pixel at a negedge, waits for its accept, returns at the following negedge.
  task automatic send(input int base, input bit sof);
    int n;
    bit last;
    if (sof) begin
      pos_r = 0;
      pos_c = 0;
    end
    pix_in    = pv(base, pos_r, pos_c);
    pix_sof   = sof;
    pix_valid = 1'b1;
    #1;
    n = 0;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!pix_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    if (pos_r >= 2 && pos_c >= 2) exp_q.push_back(model_win(base, pos_r, pos_c));
    last = (pos_r == H - 1) && (pos_c == W - 1);
    if (pos_c == W - 1) begin
      pos_c = 0;
      pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
    end else begin
      pos_c++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
`ifdef WINDOW_FEEDER_FRAME_DONE_EN
    #2;
    check("frame_done", 72'(frame_done), 72'(last));
    @(negedge clk);
    check("frame_done_clear", 72'(frame_done), 72'(0));
`else
    if (last) pos_c = pos_c;
`endif
  endtask

  task automatic send_n(input int base, input bit sof_first, input int n);
    for (int k = 0; k < n; k++) send(base, sof_first && (k == 0));
  endtask

  task automatic drain_and_count(input string name, input int start, input int req);
    repeat (4) @(negedge clk);
    check(name, 72'(wins - start), 72'(req));
    check({name, "_queue"}, 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    int start;
    window_t held;
    rst_n = 1'b0; pix_in = '0; pix_sof = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_window", 72'(cur_win()), 72'(0));
    check("reset_valid", 72'(win_valid), 72'(0));
    check("reset_ready", 72'(pix_ready), 72'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame, free-running downstream.
    start = wins;
    send_n(8'h00, 1'b1, W * H);
    drain_and_count("frame1_count", start, 4);

    // Stall after the first window.
    start = wins;
    send_n(8'h00, 1'b1, 11);
    win_ready = 1'b0;
    pix_in    = pv(8'h00, 2, 3);
    pix_valid = 1'b1;
    held = model_win(8'h00, 2, 2);
    for (int k = 0; k < 5; k++) begin
      #2;
      check("stall_ready", 72'(pix_ready), 72'(0));
      check("stall_window", 72'(cur_win()), 72'(held));
      @(negedge clk);
    end
    win_ready = 1'b1;
    send_n(8'h00, 1'b0, W * H - 11);
    drain_and_count("stall_count", start, 4);

    // Mid-frame restart: partial frame abandoned.
    start = wins;
    send_n(8'h00, 1'b1, 10);
    send_n(8'h40, 1'b1, W * H);
    drain_and_count("sof_count", start, 4);

    // Asynchronous reset in the middle of row 2.
    send_n(8'h00, 1'b1, 11);
    repeat (3) @(negedge clk);
    pix_in = 8'h55; pix_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_window", 72'(cur_win()), 72'(0));
    check("arst_valid", 72'(win_valid), 72'(0));
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    pos_r = 0;
    pos_c = 0;
    exp_q.delete();
    @(negedge clk);
    start = wins;
    send_n(8'hC0, 1'b0, W * H);
    drain_and_count("post_reset_count", start, 4);

    // Back-to-back frames, second frame uses distinct values.
    start = wins;
    send_n(8'h00, 1'b1, W * H);
    send_n(8'h80, 1'b1, W * H);
    drain_and_count("b2b_count", start, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
